cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer.sv | 96 +++++++++
 tb/tb_cpu_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Fetch/execute bus between cpu_sequencer, the instruction ROM and the decoder.
// SEQ_SINGLE_STEP_EN adds the step_mode/step controls.
interface cpu_sequencer_if;
  logic        run;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] ir;
  logic [7:0]  pc;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        exec_en;
  logic        halted;
  logic        busy;
  logic [15:0] retired;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode;
  logic        step;

  modport slave (
    input  run, rom_data, jump_en, jump_addr, step_mode, step,
    output rom_addr, ir, pc, exec_en, halted, busy, retired
  );

  modport master (
    output run, rom_data, jump_en, jump_addr, step_mode, step,
    input  rom_addr, ir, pc, exec_en, halted, busy, retired
  );
`else
  modport slave (
    input  run, rom_data, jump_en, jump_addr,
    output rom_addr, ir, pc, exec_en, halted, busy, retired
  );

  modport master (
    output run, rom_data, jump_en, jump_addr,
    input  rom_addr, ir, pc, exec_en, halted, busy, retired
  );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns the PC, latches the instruction word, emits one exec_en per instruction.
// Optional single-step control is enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter logic [7:0] OPC_RD   = 8'h13,
  parameter logic [7:0] OPC_HLT  = 8'hFF,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_MEMW,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_pc;
  logic [23:0] r_ir;
  logic        r_exec_en;
  logic        r_halted;
  logic        r_busy;
  logic [15:0] r_retired;
  logic        w_start;
  logic        w_continue;
  logic [7:0]  w_opcode;

  assign w_opcode = bus.rom_data[23:16];

`ifdef SEQ_SINGLE_STEP_EN
  // In step mode a pulse is only honoured from IDLE, and EXEC always parks back in IDLE.
  assign w_start    = bus.step_mode ? bus.step : bus.run;
  assign w_continue = bus.run & ~bus.step_mode;
`else
  assign w_start    = bus.run;
  assign w_continue = bus.run;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_FETCH;
      S_FETCH: w_next = S_LATCH;
      S_LATCH: begin
        if (w_opcode == OPC_RD)       w_next = S_MEMW;
        else if (w_opcode == OPC_HLT) w_next = S_HALT;
        else                          w_next = S_EXEC;
      end
      S_MEMW:  w_next = S_EXEC;
      S_EXEC:  w_next = w_continue ? S_FETCH : S_IDLE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_exec_en <= 1'b0;
      r_halted  <= 1'b0;
      r_busy    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_exec_en <= (w_next == S_EXEC);
      r_halted  <= (w_next == S_HALT);
      r_busy    <= (w_next != S_IDLE) && (w_next != S_HALT);
      if (r_state == S_LATCH) r_ir <= bus.rom_data;
      if (r_state == S_EXEC) begin
        r_pc      <= bus.jump_en ? bus.jump_addr : r_pc + 8'd1;
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign bus.rom_addr = r_pc;
  assign bus.pc       = r_pc;
  assign bus.ir       = r_ir;
  assign bus.exec_en  = r_exec_en;
  assign bus.halted   = r_halted;
  assign bus.busy     = r_busy;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed ROM programs, expected commits queued, monitor checks each exec_en.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [7:0]  pc;
    logic [23:0] ir;
    logic [15:0] ret;
  } commit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(
    .OPC_RD  (8'h13),
    .OPC_HLT (8'hFF),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [23:0] rom [256];
  logic [23:0] rom_q;
  commit_t     exp_q [$];
  commit_t     mon_e;
  int          checks   = 0;
  int          failures = 0;

  // Synchronous ROM and a decoder stand-in: opcode 8'h20 jumps to ir[7:0].
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data  = rom_q;
  assign bus.jump_en   = (bus.ir[23:16] == 8'h20);
  assign bus.jump_addr = bus.ir[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] p, input logic [23:0] i, input logic [15:0] r);
    commit_t c;
    c.pc  = p;
    c.ir  = i;
    c.ret = r;
    exp_q.push_back(c);
  endtask

  task automatic fill_rom;
    for (int i = 0; i < 256; i++) rom[i] = 24'hFF0000;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick(1);
    chk({tag, "_rst_pc"},      32'(bus.pc),      32'h0);
    chk({tag, "_rst_ir"},      32'(bus.ir),      32'h0);
    chk({tag, "_rst_exec"},    32'(bus.exec_en), 32'h0);
    chk({tag, "_rst_halted"},  32'(bus.halted),  32'h0);
    chk({tag, "_rst_busy"},    32'(bus.busy),    32'h0);
    chk({tag, "_rst_retired"}, 32'(bus.retired), 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.exec_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit actual_pc=%0h actual_ir=%0h expected=no_commit", bus.pc, bus.ir);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_pc",      32'(bus.pc),      32'(mon_e.pc));
          chk("commit_ir",      32'(bus.ir),      32'(mon_e.ir));
          chk("commit_retired", 32'(bus.retired), 32'(mon_e.ret));
        end
      end
    end
  end

  initial begin
    bus.run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
`endif
    fill_rom();
    tick(1);
    do_reset("init");

    // Three NOPs, run dropped during the third FETCH
    rom[0] = 24'h000000; rom[1] = 24'h000011; rom[2] = 24'h000022;
    push(8'h00, 24'h000000, 16'd0);
    push(8'h01, 24'h000011, 16'd1);
    push(8'h02, 24'h000022, 16'd2);
    bus.run = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("nop_fetch_busy", 32'(bus.busy), 32'h1);
    chk("nop_fetch_exec", 32'(bus.exec_en), 32'h0);
    tick(2);
    chk("nop_first_exec", 32'(bus.exec_en), 32'h1);
    tick(4);
    chk("nop_pc_e7", 32'(bus.pc), 32'h2);
    bus.run = 1'b0;
    tick(3);
    chk("nop_idle_busy", 32'(bus.busy), 32'h0);
    chk("nop_idle_pc", 32'(bus.pc), 32'h3);
    chk("nop_retired3", 32'(bus.retired), 32'h3);
    tick(3);
    chk("nop_stay_idle_pc", 32'(bus.pc), 32'h3);
    do_reset("a");

    // Jump at ROM[5] to 8'h40, then HLT at 8'h41
    fill_rom();
    for (int k = 0; k < 5; k++) begin
      rom[k] = 24'(k);
      push(8'(k), 24'(k), 16'(k));
    end
    rom[5] = 24'h200040; rom[8'h40] = 24'h000055;
    push(8'h05, 24'h200040, 16'd5);
    push(8'h40, 24'h000055, 16'd6);
    bus.run = 1'b1;
    rst = 1'b0;
    tick(19);
    chk("jump_target", 32'(bus.rom_addr), 32'h40);
    chk("jump_retired", 32'(bus.retired), 32'h6);
    tick(7);
    chk("hlt_halted", 32'(bus.halted), 32'h1);
    chk("hlt_busy", 32'(bus.busy), 32'h0);
    chk("hlt_exec", 32'(bus.exec_en), 32'h0);
    chk("hlt_retired", 32'(bus.retired), 32'h7);
    chk("hlt_pc", 32'(bus.pc), 32'h41);
    chk("hlt_ir", 32'(bus.ir), 32'hFF0000);
    do_reset("b");

    // RAM-read opcode takes an extra MEMW cycle
    fill_rom();
    rom[0] = 24'h000001; rom[1] = 24'h130005;
    push(8'h00, 24'h000001, 16'd0);
    push(8'h01, 24'h130005, 16'd1);
    rst = 1'b0;
    tick(6);
    chk("memw_exec_low", 32'(bus.exec_en), 32'h0);
    chk("memw_busy", 32'(bus.busy), 32'h1);
    chk("memw_ir", 32'(bus.ir), 32'h130005);
    tick(1);
    chk("rd_exec_high", 32'(bus.exec_en), 32'h1);
    tick(1);
    chk("rd_pc_after", 32'(bus.pc), 32'h2);
    chk("rd_retired", 32'(bus.retired), 32'h2);
    tick(4);
    chk("rd_then_halt", 32'(bus.halted), 32'h1);
    do_reset("c");

    // PC wrap 8'hFF -> 8'h00, run dropped during FETCH
    fill_rom();
    rom[0] = 24'h2000FF; rom[8'hFF] = 24'h0000AB;
    push(8'h00, 24'h2000FF, 16'd0);
    push(8'hFF, 24'h0000AB, 16'd1);
    push(8'h00, 24'h2000FF, 16'd2);
    rst = 1'b0;
    tick(7);
    chk("pc_wrap", 32'(bus.pc), 32'h0);
    chk("pc_wrap_rom_addr", 32'(bus.rom_addr), 32'h0);
    bus.run = 1'b0;
    tick(3);
    chk("run_drop_idle", 32'(bus.busy), 32'h0);
    chk("run_drop_pc", 32'(bus.pc), 32'hFF);
    chk("run_drop_retired", 32'(bus.retired), 32'h3);
    do_reset("d");

    // Reset asserted during LATCH: no commit
    fill_rom();
    rom[0] = 24'h000099;
    bus.run = 1'b1;
    rst = 1'b0;
    tick(2);
    chk("latch_busy", 32'(bus.busy), 32'h1);
    do_reset("e");
    tick(3);
    chk("post_rst_idle_pc", 32'(bus.pc), 32'h0);

    // HLT at ROM[0], held until reset
    fill_rom();
    rst = 1'b0;
    tick(5);
    chk("hlt0_halted", 32'(bus.halted), 32'h1);
    chk("hlt0_exec", 32'(bus.exec_en), 32'h0);
    chk("hlt0_retired", 32'(bus.retired), 32'h0);
    chk("hlt0_pc", 32'(bus.pc), 32'h0);
    bus.run = 1'b0;
    tick(3);
    chk("hlt0_sticky", 32'(bus.halted), 32'h1);
    do_reset("f");

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: run ignored, one instruction per pulse, pulse while busy dropped
    fill_rom();
    for (int k = 0; k < 4; k++) rom[k] = 24'(k);
    bus.run = 1'b1;
    bus.step_mode = 1'b1;
    rst = 1'b0;
    tick(4);
    chk("step_no_fetch", 32'(bus.busy), 32'h0);
    for (int k = 0; k < 3; k++) push(8'(k), 24'(k), 16'(k));
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
      if (k == 0) begin
        tick(1);
        bus.step = 1'b1;
        tick(1);
        bus.step = 1'b0;
        tick(7);
      end else begin
        tick(9);
      end
    end
    chk("step_pc", 32'(bus.pc), 32'h3);
    chk("step_retired", 32'(bus.retired), 32'h3);
    chk("step_idle", 32'(bus.busy), 32'h0);
    bus.step_mode = 1'b0;
    bus.run = 1'b0;
    do_reset("g");
`endif

    tick(5);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
